// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front end: conditions the raw PS/2 lines, frames bytes, decodes
// WASD / arrow make-break codes and drives held-level move requests.
module ps2_move_decoder #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TIMEOUT_US      = 200,
    parameter int GLITCH_CYCLES   = 8
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iPS2Clk,
    input  logic       iPS2Dat,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oFrameErr,
    output logic       oForwardX,
    output logic       oBackX,
    output logic       oForwardY,
    output logic       oBackY
);
    localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
    localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GF_W           = $clog2(GLITCH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    typedef enum logic [2:0] {K_W, K_A, K_S, K_D, K_UP, K_LEFT, K_DOWN, K_RIGHT} key_t;

    logic [1:0]      clk_sync, dat_sync;
    logic            clk_filt;
    logic [GF_W-1:0] gf_cnt;
    logic            differ, gf_flip, sample, dat;

    state_t          state, next_state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity_bit;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout, frame_good, frame_bad;

    logic            ext, brk, hit;
    key_t            key;
    logic [7:0]      held;
    logic            fx, bx, fy, by;

    // Synchronizers and glitch filter idle high, matching an idle PS/2 bus.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], iPS2Clk};
            dat_sync <= {dat_sync[0], iPS2Dat};
        end
    end

    assign differ  = clk_sync[1] != clk_filt;
    assign gf_flip = differ && (gf_cnt == GF_W'(GLITCH_CYCLES - 1));
    assign sample  = gf_flip && clk_filt;
    assign dat     = dat_sync[1];

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            clk_filt <= 1'b1;
            gf_cnt   <= '0;
        end else if (!differ) begin
            gf_cnt   <= '0;
        end else if (gf_flip) begin
            gf_cnt   <= '0;
            clk_filt <= clk_sync[1];
        end else begin
            gf_cnt   <= gf_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !sample && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: each comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (sample) begin
            case (state)
                IDLE:    if (!dat) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_good = 1'b0;
        frame_bad  = timeout;
        if (state == STOP && sample) begin
            if (dat && ^{shift, parity_bit}) frame_good = 1'b1;
            else                             frame_bad  = 1'b1;
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            if (state == IDLE || sample) wd_cnt <= '0;
            else                         wd_cnt <= wd_cnt + 1'b1;
            if (sample) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift   <= {dat, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: parity_bit <= dat;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        key = K_W;
        if (!ext) begin
            case (shift)
                8'h1D: begin hit = 1'b1; key = K_W; end
                8'h1C: begin hit = 1'b1; key = K_A; end
                8'h1B: begin hit = 1'b1; key = K_S; end
                8'h23: begin hit = 1'b1; key = K_D; end
                default: ;
            endcase
        end else begin
            case (shift)
                8'h75: begin hit = 1'b1; key = K_UP;    end
                8'h6B: begin hit = 1'b1; key = K_LEFT;  end
                8'h72: begin hit = 1'b1; key = K_DOWN;  end
                8'h74: begin hit = 1'b1; key = K_RIGHT; end
                default: ;
            endcase
        end
    end

    // A bad or timed-out frame may have swallowed the code a prefix referred to.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oScanCode  <= '0;
            oScanValid <= 1'b0;
            oFrameErr  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            held       <= '0;
        end else begin
            oScanValid <= frame_good;
            oFrameErr  <= frame_bad;
            if (frame_good) begin
                oScanCode <= shift;
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    if (hit) held[key] <= ~brk;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end else if (frame_bad) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    assign fx = held[K_D] | held[K_RIGHT];
    assign bx = held[K_A] | held[K_LEFT];
    assign fy = held[K_S] | held[K_DOWN];
    assign by = held[K_W] | held[K_UP];

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oForwardX <= 1'b0;
            oBackX    <= 1'b0;
            oForwardY <= 1'b0;
            oBackY    <= 1'b0;
        end else begin
            oForwardX <= fx & ~bx;
            oBackX    <= bx & ~fx;
            oForwardY <= fy & ~by;
            oBackY    <= by & ~fy;
        end
    end
endmodule

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: bit-bangs PS/2 frames, scoreboards scan/error
// pulses and checks the move outputs after each key sequence.
module tb_ps2_move_decoder;
    localparam int HALF = 20;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk, ps2_dat;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;
    logic       fwd_x, back_x, fwd_y, back_y;

    sb_item_t   sb[$];
    int         total = 0;
    int         bad   = 0;
    logic       prev_valid = 1'b0;
    logic       prev_err   = 1'b0;

    ps2_move_decoder #(
        .CLOCK_FREQUENCY(50000000),
        .TIMEOUT_US     (20),
        .GLITCH_CYCLES  (8)
    ) dut (
        .iClock    (clk),
        .iResetn   (rst_n),
        .iPS2Clk   (ps2_clk),
        .iPS2Dat   (ps2_dat),
        .oScanCode (scan_code),
        .oScanValid(scan_valid),
        .oFrameErr (frame_err),
        .oForwardX (fwd_x),
        .oBackX    (back_x),
        .oForwardY (fwd_y),
        .oBackY    (back_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        sb_item_t it;
        if (prev_valid) check("valid_width", 32'(scan_valid), 0);
        if (prev_err)   check("err_width", 32'(frame_err), 0);
        if (scan_valid || frame_err) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {30'd0, scan_valid, frame_err}, 0);
            end else begin
                it = sb.pop_front();
                check("sb_kind", {30'd0, scan_valid, frame_err}, {30'd0, ~it.is_err, it.is_err});
                if (!it.is_err) check("sb_code", 32'(scan_code), 32'(it.code));
            end
        end
        prev_valid = scan_valid;
        prev_err   = frame_err;
    end

    task automatic send_bit(input logic v);
        ps2_dat = v;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drain", sb.size(), 0);
        sb.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        logic [10:0] bits;
        sb_item_t    it;
        bits      = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        it.is_err = bad_par | bad_stop;
        it.code   = b;
        sb.push_back(it);
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_dat = 1'b1;
        wait_drain();
    endtask

    task automatic send_partial(input int n_data);
        send_bit(1'b0);
        for (int i = 0; i < n_data; i++) send_bit(i[0]);
        ps2_dat = 1'b1;
    endtask

    task automatic check_dirs(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, fwd_x, back_x, fwd_y, back_y}, {28'd0, exp});
    endtask

    initial begin
        sb_item_t it;
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_code", 32'(scan_code), 0);
        check("rst_pulses", {30'd0, scan_valid, frame_err}, 0);
        check_dirs("rst_dirs", 4'b0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // W press / release
        send_frame(8'h1D);              check_dirs("w_make", 4'b0001);
        send_frame(8'hF0); send_frame(8'h1D); check_dirs("w_break", 4'b0000);

        // right arrow and D are independent contributors to +X
        send_frame(8'hE0); send_frame(8'h74); check_dirs("right_make", 4'b1000);
        send_frame(8'h23);                    check_dirs("d_make", 4'b1000);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h74);
        check_dirs("right_break_d_held", 4'b1000);
        send_frame(8'hF0); send_frame(8'h23); check_dirs("d_break", 4'b0000);

        // opposing X requests cancel
        send_frame(8'h1C);                    check_dirs("a_make", 4'b0100);
        send_frame(8'h23);                    check_dirs("a_d_cancel", 4'b0000);
        send_frame(8'hF0); send_frame(8'h1C); check_dirs("a_break", 4'b1000);
        send_frame(8'hF0); send_frame(8'h23); check_dirs("x_clear", 4'b0000);

        // unmatched codes: E0-less 75 and E1 change nothing
        send_frame(8'h75); send_frame(8'hE1); check_dirs("unmatched", 4'b0000);

        // parity / stop errors drop the byte and clear a pending break prefix
        send_frame(8'h1D);                    check_dirs("w_hold", 4'b0001);
        send_frame(8'h1C, 1, 0);              check_dirs("bad_parity", 4'b0001);
        send_frame(8'hF0); send_frame(8'h23, 0, 1);
        send_frame(8'h1D);                    check_dirs("brk_cleared", 4'b0001);
        send_frame(8'hF0); send_frame(8'h1D); check_dirs("w_release", 4'b0000);

        // partial frame times out, then decoding resumes
        it.is_err = 1'b1;
        it.code   = 8'h00;
        sb.push_back(it);
        send_partial(5);
        wait_drain();
        send_frame(8'h1B);                    check_dirs("s_after_timeout", 4'b0010);

        // short low glitch in IDLE must not be taken as a start bit
        @(negedge clk);
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h1C);                    check_dirs("a_after_glitch", 4'b0110);

        // reset mid-frame clears everything immediately
        send_partial(3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_code", 32'(scan_code), 0);
        check("midrst_pulses", {30'd0, scan_valid, frame_err}, 0);
        check_dirs("midrst_dirs", 4'b0000);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h23);                    check_dirs("d_after_reset", 4'b1000);
        check("final_code", 32'(scan_code), 32'h23);

        repeat (20) @(negedge clk);
        check("sb_final_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
